sine_phase_acc: RTL and testbench
=================================

Name: sine_phase_acc

Overview:
- Phase-accumulator address generator that sits directly upstream of the synchronous sine ROM.
- Each enabled cycle it adds a programmable frequency increment to an accumulator. The top ADDRESS_WIDTH bits drive the ROM address.
- Increment updates are taken through a valid/ready handshake and deferred to a phase wrap, so the output waveform never glitches.
- Provides a valid flag aligned with the ROM's one-cycle read latency.

Parameters:
- ADDRESS_WIDTH, 8, ROM address width; must be <= ACC_WIDTH.
- ACC_WIDTH, 16, accumulator and increment width.
- INCR_RESET, 256, increment loaded at reset (one ROM step per cycle at default widths).

Ports:
- clk  input  1  clock; all logic on the rising edge.
- rst_n  input  1  synchronous, active-low reset.
- en  input  1  advance the phase when high; hold when low.
- incr_in  input  ACC_WIDTH  new frequency increment.
- incr_valid  input  1  incr_in is valid.
- incr_ready  output  1  block can accept an increment.
- offset  input  ADDRESS_WIDTH  phase offset for addr2 (only with PHASE_OFFSET_EN).
- addr  output  ADDRESS_WIDTH  ROM address, acc[ACC_WIDTH-1 -: ADDRESS_WIDTH].
- addr2  output  ADDRESS_WIDTH  offset ROM address (only with PHASE_OFFSET_EN).
- wrap  output  1  one-cycle pulse when the accumulator overflows.
- rom_valid  output  1  ROM dout for the previous addr is valid this cycle.

Behaviour:
- Reset (rst_n=0 at an edge): acc=0, incr_reg=INCR_RESET, pending register cleared, state=IDLE, wrap=0, rom_valid=0, addr=0, addr2=offset.
  - Reset overrides every other input.
  - A pending increment is discarded.
- Accumulator
  - When en=1: acc <= (acc + incr_reg) mod 2^ACC_WIDTH.
  - wrap <= carry-out of that add, registered; it is high in the same cycle addr shows the wrapped value.
  - When en=0: acc holds and wrap=0.
- addr is a direct slice of the acc register, so it is registered with no combinational path from inputs.
- rom_valid <= en, a 1-cycle delay matching the ROM's registered read.
- States: IDLE, RUN, PEND.
  - IDLE: en=0; incr_ready=1. On incr_valid, incr_reg <= incr_in, effective from the next add. en=1 -> RUN.
  - RUN: incr_ready=1. On incr_valid, pend <= incr_in -> PEND. en=0 -> IDLE.
  - PEND: incr_ready=0.
    - Exit 1: on the first add that carries out, incr_reg <= pend for the following add -> RUN.
    - Exit 2: if en=0, apply pend immediately -> IDLE.
    - Exit 3: if incr_reg=0 (no wrap can ever occur), apply pend next cycle -> RUN.
- Simultaneous events
  - incr_valid accepted in RUN in the same cycle a carry occurs: that carry does not consume it; it is applied at the next wrap.
  - incr_valid and en falling together in RUN: increment captured to pend; next cycle the PEND/en=0 rule applies it -> IDLE.
- Arithmetic
  - All adds are unsigned modulo 2^ACC_WIDTH.
  - incr=0 freezes the phase while rom_valid still follows en.
  - ADDRESS_WIDTH==ACC_WIDTH is legal (no fractional bits).

Optional Feature:
- Macro: PHASE_OFFSET_EN.
- Defined:
  - offset port and addr2 exist.
  - addr2 = (acc[ACC_WIDTH-1 -: ADDRESS_WIDTH] + offset) mod 2^ADDRESS_WIDTH, registered alongside acc so addr and addr2 change in the same cycle.
  - addr2 is intended for a second ROM read port (quadrature or dual-channel output).
- Undefined: offset and addr2 are absent; no adder is instantiated.

Test Plan:
- Reset, then en=1 for 300 cycles at defaults -> addr steps 0,1,…,255,0,1; wrap=1 only in the cycle addr returns to 0 (256th add); rom_valid rises one cycle after en.
- In RUN at acc=0x1000, send incr_in=0x0180 with incr_valid -> incr_ready=0 next cycle; step stays 0x0100 until the wrap; afterwards acc advances by 0x0180 per cycle (addr steps 1,2 alternating); incr_ready returns to 1.
- incr_in=0x8000 applied in IDLE, then en=1 -> addr alternates 128,0,128…; wrap pulses every second cycle.
- en=0 mid-run at addr=77 -> addr holds 77; rom_valid falls one cycle later; an increment sent in IDLE is applied immediately with no deferral.
- rst_n=0 while in PEND -> next cycle acc=0, incr_reg=256, incr_ready=1, wrap=0, rom_valid=0; the pending increment is never applied.
- PHASE_OFFSET_EN, offset=64 -> addr=200 gives addr2=8; addr=0 gives addr2=64; both change on the same edge.

Source files
------------

// File: rtl/sine_phase_acc.sv
// sine_phase_acc: phase-accumulator address generator for a synchronous sine ROM.
//
// Each enabled cycle the accumulator advances by a programmable increment. Its top
// ADDRESS_WIDTH bits form the ROM address. New increments arrive over a valid/ready
// handshake. While the phase is running, a new increment is held until the next
// phase wrap so the waveform never jumps mid-cycle.
//
// Optional feature macro: PHASE_OFFSET_EN
//   When defined, adds the offset input and the addr2 output. addr2 is the addr value
//   plus offset, intended for a second ROM read port. It is registered together with
//   acc, so addr and addr2 always change on the same clock edge.
//
// Handshake: an increment transfers on a rising edge where incr_valid && incr_ready.
// incr_ready depends only on registered state. The source may hold incr_valid and
// incr_in for as long as it needs to.

module sine_phase_acc #(
    parameter int          ADDRESS_WIDTH = 8,
    parameter int          ACC_WIDTH     = 16,
    parameter int unsigned INCR_RESET    = 256
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic [ACC_WIDTH-1:0]     incr_in,
    input  logic                     incr_valid,
    output logic                     incr_ready,
`ifdef PHASE_OFFSET_EN
    input  logic [ADDRESS_WIDTH-1:0] offset,
    output logic [ADDRESS_WIDTH-1:0] addr2,
`endif
    output logic [ADDRESS_WIDTH-1:0] addr,
    output logic                     wrap,
    output logic                     rom_valid,
    output logic [1:0]               state_dbg
);

    // IDLE: phase held. RUN: phase advancing. PEND: a deferred increment is waiting.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        PEND = 2'd2
    } state_t;

    state_t               state;
    logic [ACC_WIDTH-1:0] acc;
    logic [ACC_WIDTH-1:0] incr_reg;
    logic [ACC_WIDTH-1:0] pend;
    logic [ACC_WIDTH:0]   sum;
    logic                 carry;

    // The extra top bit of sum is the carry-out. It marks a phase wrap.
    assign sum        = {1'b0, acc} + {1'b0, incr_reg};
    assign carry      = sum[ACC_WIDTH];

    assign addr       = acc[ACC_WIDTH-1 -: ADDRESS_WIDTH];
    assign incr_ready = (state != PEND);
    assign state_dbg  = state;

    // Accumulator, wrap pulse, ROM-latency valid, and the increment-update FSM.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc       <= '0;
            incr_reg  <= ACC_WIDTH'(INCR_RESET);
            pend      <= '0;
            wrap      <= 1'b0;
            rom_valid <= 1'b0;
            state     <= IDLE;
        end else begin
            if (en) begin
                acc  <= sum[ACC_WIDTH-1:0];
                wrap <= carry;
            end else begin
                wrap <= 1'b0;
            end
            rom_valid <= en;

            case (state)
                IDLE: begin
                    // The phase is not running, so an increment can be applied at once.
                    if (incr_valid) begin
                        incr_reg <= incr_in;
                    end
                    if (en) begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    // A carry in this same cycle does not count. Wait for the next wrap.
                    if (incr_valid) begin
                        pend  <= incr_in;
                        state <= PEND;
                    end else if (!en) begin
                        state <= IDLE;
                    end
                end
                PEND: begin
                    if (!en) begin
                        incr_reg <= pend;
                        state    <= IDLE;
                    end else if (carry || (incr_reg == '0)) begin
                        // A zero step can never wrap, so apply the new step right away.
                        incr_reg <= pend;
                        state    <= RUN;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef PHASE_OFFSET_EN
    logic [ACC_WIDTH-1:0] acc_next;

    assign acc_next = en ? sum[ACC_WIDTH-1:0] : acc;

    // Offset address computed from next-cycle acc so it lands on the same edge as addr.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            addr2 <= offset;
        end else begin
            addr2 <= acc_next[ACC_WIDTH-1 -: ADDRESS_WIDTH] + offset;
        end
    end
`endif

endmodule

// File: tb/tb_sine_phase_acc.sv
// Testbench for sine_phase_acc: directed scenarios plus random traffic.
// A behavioural model predicts every cycle's outputs into a queue.
// A negedge monitor pops each prediction and compares it with the DUT outputs.

module tb_sine_phase_acc;

  localparam int AW = 8;
  localparam int CW = 16;
  localparam longint MOD = longint'(1) << CW;
  localparam longint ASCALE = longint'(1) << (CW - AW);
`ifdef PHASE_OFFSET_EN
  localparam int EW = 2 * AW + 3;
`else
  localparam int EW = AW + 3;
`endif

  logic          clk;
  logic          rst_n;
  logic          en;
  logic [CW-1:0] incr_in;
  logic          incr_valid;
  logic          incr_ready;
  logic [AW-1:0] offset;
  logic [AW-1:0] addr2;
  logic [AW-1:0] addr;
  logic          wrap;
  logic          rom_valid;
  logic [1:0]    state_dbg;

  logic [EW-1:0] exp_q[$];
  int n_checks;
  int n_fail;

  sine_phase_acc #(
    .ADDRESS_WIDTH(AW),
    .ACC_WIDTH(CW),
    .INCR_RESET(256)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .en(en),
    .incr_in(incr_in),
    .incr_valid(incr_valid),
    .incr_ready(incr_ready),
`ifdef PHASE_OFFSET_EN
    .offset(offset),
    .addr2(addr2),
`endif
    .addr(addr),
    .wrap(wrap),
    .rom_valid(rom_valid),
    .state_dbg(state_dbg)
  );

`ifndef PHASE_OFFSET_EN
  assign addr2 = '0;
`endif

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model. The phase counts as running when en was high on the previous
  // edge. A running phase defers an accepted increment to the next wrap. A stopped
  // phase applies it immediately.
  longint m_acc;
  longint m_incr;
  longint m_pend;
  bit     m_pend_v;
  bit     m_run;

  task automatic model_step();
    longint s;
    bit c;
    longint a;
    logic [EW-1:0] e;
    c = 1'b0;
    if (!rst_n) begin
      m_acc = 0;
      m_incr = 256;
      m_pend_v = 1'b0;
      m_run = 1'b0;
    end else begin
      s = m_acc + m_incr;
      c = en && (s >= MOD);
      if (m_pend_v) begin
        if (!en || c || m_incr == 0) begin
          m_incr = m_pend;
          m_pend_v = 1'b0;
        end
      end else if (incr_valid) begin
        if (m_run) begin
          m_pend = longint'(incr_in);
          m_pend_v = 1'b1;
        end else begin
          m_incr = longint'(incr_in);
        end
      end
      if (en) m_acc = s % MOD;
      m_run = en;
    end
    a = m_acc / ASCALE;
`ifdef PHASE_OFFSET_EN
    e = {AW'(a), c, m_run, ~m_pend_v, AW'((a + longint'(offset)) % (longint'(1) << AW))};
`else
    e = {AW'(a), c, m_run, ~m_pend_v};
`endif
    exp_q.push_back(e);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  // Scoreboard monitor: one comparison per predicted cycle.
  initial begin
    logic [EW-1:0] e;
    logic [EW-1:0] g;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
`ifdef PHASE_OFFSET_EN
        g = {addr, wrap, rom_valid, incr_ready, addr2};
`else
        g = {addr, wrap, rom_valid, incr_ready};
`endif
        n_checks++;
        if (g !== e) begin
          n_fail++;
          $display("FAIL outputs t=%0t {addr,wrap,rom_valid,incr_ready[,addr2]} got=%h exp=%h",
                   $time, g, e);
        end
      end
    end
  end

  // driver
  task automatic step(input bit r, input bit e, input bit v, input logic [CW-1:0] inc);
    @(negedge clk);
    rst_n = r;
    en = e;
    incr_valid = v;
    incr_in = inc;
  endtask

  task automatic run_cycles(input bit e, input int n);
    for (int i = 0; i < n; i++) step(1'b1, e, 1'b0, '0);
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    rst_n = 1'b0;
    en = 1'b0;
    incr_valid = 1'b0;
    incr_in = '0;
    offset = 8'd64;

    // reset, then free-run at default step through more than one full wrap
    step(1'b0, 1'b0, 1'b0, '0);
    step(1'b0, 1'b0, 1'b0, '0);
    run_cycles(1'b1, 300);

    // deferred increment: acc=0x1000 after 16 adds, then request 0x0180
    step(1'b0, 1'b0, 1'b0, '0);
    run_cycles(1'b1, 16);
    step(1'b1, 1'b1, 1'b1, 16'h0180);
    run_cycles(1'b1, 300);

    // half-scale step loaded in IDLE
    step(1'b0, 1'b0, 1'b0, '0);
    step(1'b1, 1'b0, 1'b1, 16'h8000);
    run_cycles(1'b1, 10);

    // stop at addr=77, load in IDLE, restart
    offset = 8'd200;
    step(1'b0, 1'b0, 1'b0, '0);
    run_cycles(1'b1, 77);
    run_cycles(1'b0, 3);
    step(1'b1, 1'b0, 1'b1, 16'h0300);
    run_cycles(1'b1, 20);

    // valid and en falling together in RUN
    step(1'b1, 1'b0, 1'b1, 16'h0040);
    run_cycles(1'b0, 2);
    run_cycles(1'b1, 10);

    // reset while PEND discards the pending step
    step(1'b1, 1'b1, 1'b1, 16'h0777);
    run_cycles(1'b1, 3);
    step(1'b0, 1'b1, 1'b0, '0);
    run_cycles(1'b1, 300);

    // zero step freezes phase; a new step then applies without waiting for a wrap
    step(1'b1, 1'b0, 1'b1, 16'h0000);
    run_cycles(1'b1, 5);
    step(1'b1, 1'b1, 1'b1, 16'h0100);
    run_cycles(1'b1, 10);

    // full-range step and an all-ones step
    step(1'b1, 1'b0, 1'b1, 16'hFFFF);
    run_cycles(1'b1, 8);

    // random traffic
    for (int i = 0; i < 4000; i++) begin
      bit r;
      bit e;
      bit v;
      logic [CW-1:0] inc;
      r = ($urandom_range(0, 199) != 0);
      e = ($urandom_range(0, 9) < 8);
      v = ($urandom_range(0, 9) == 0);
      inc = ($urandom_range(0, 3) == 0) ? CW'($urandom_range(0, 3)) : CW'($urandom);
      if ($urandom_range(0, 49) == 0) offset = AW'($urandom);
      step(r, e, v, inc);
    end

    run_cycles(1'b0, 3);
    @(negedge clk);
    #1;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain queue_left=%0d exp=0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
